// File: rtl/serial_frame_pkg.sv
// Shared types for the serial frame receiver.
//   state_t   : receiver FSM states (IDLE, DATA, PARITY)
//   START_BIT : line level that opens a frame (the line idles low)
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic START_BIT = 1'b1;

endpackage

// File: rtl/sfr_shift_reg.sv
// WIDTH-bit LSB-first shift register with a running XOR of every bit shifted in.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the word and parity (takes priority over shift_en)
//   shift_en   : shift d in on this edge
//   d          : serial bit
//   word       : assembled word; after WIDTH shifts the first bit sits at bit 0
//   parity     : XOR of all bits shifted in since the last clear
module sfr_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             d,
    output logic [WIDTH-1:0] word,
    output logic             parity
);

    // New bits enter at the MSB and move down, so the first bit received
    // lands in bit 0 once the whole word is in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word   <= '0;
            parity <= 1'b0;
        end else if (clear) begin
            word   <= '0;
            parity <= 1'b0;
        end else if (shift_en) begin
            word   <= {d, word[WIDTH-1:1]};
            parity <= parity ^ d;
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Single-wire serial frame receiver: start bit, WIDTH data bits LSB-first,
// optional even-parity bit, delivered through a one-entry valid/ready buffer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   d           : serial input, one bit per clk
//   data_out    : received word, stable while valid=1
//   valid       : data_out holds an unconsumed word
//   ready       : consumer accepts (handshake = valid & ready)
//   parity_err  : parity mismatch for the word in data_out
//   overrun     : sticky, a completed frame was dropped because the buffer was full
//   busy        : receiver is inside a frame
module serial_frame_receiver
    import serial_frame_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   sr_word;
    logic               sr_parity;
    logic               last_data;
    logic               commit;
    logic               accept;
    logic               handshake;
    logic [WIDTH-1:0]   commit_word;
    logic               commit_err;

    sfr_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == IDLE),
        .shift_en (state == DATA),
        .d        (d),
        .word     (sr_word),
        .parity   (sr_parity)
    );

    assign last_data = (state == DATA) && (bit_cnt == CNT_W'(WIDTH - 1));
    assign commit    = (state == PARITY) || (last_data && (PARITY_EN == 0));
    assign handshake = valid && ready;
    // The buffer can take the new word if it is empty or drains on this edge.
    assign accept    = !valid || ready;

    // Without parity the commit happens on the edge that samples the last
    // data bit, so that bit is folded in here rather than read back later.
    assign commit_word = (state == PARITY) ? sr_word : {d, sr_word[WIDTH-1:1]};
    assign commit_err  = (state == PARITY) && (sr_parity ^ d);

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d == START_BIT) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_data)
                        state <= (PARITY_EN != 0) ? PARITY : IDLE;
                end
                PARITY:  state <= IDLE;
                default: state <= IDLE;
            endcase

            // Clear first so that a drop on the same edge leaves overrun set.
            if (handshake)
                overrun <= 1'b0;

            if (commit) begin
                if (accept) begin
                    data_out   <= commit_word;
                    valid      <= 1'b1;
                    parity_err <= commit_err;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (handshake) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
module tb_serial_frame_receiver;

    localparam int W    = 8;
    localparam int NCYC = 2500;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         d1, ready1, d0, ready0;
    logic [W-1:0] data1, data0;
    logic         valid1, perr1, ovr1, busy1;
    logic         valid0, perr0, ovr0, busy0;

    always #5 clk = ~clk;

    serial_frame_receiver #(.WIDTH(W), .PARITY_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .d(d1), .data_out(data1), .valid(valid1),
        .ready(ready1), .parity_err(perr1), .overrun(ovr1), .busy(busy1)
    );

    serial_frame_receiver #(.WIDTH(W), .PARITY_EN(0)) dut_np (
        .clk(clk), .rst_n(rst_n), .d(d0), .data_out(data0), .valid(valid0),
        .ready(ready0), .parity_err(perr0), .overrun(ovr0), .busy(busy0)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB-first, parity bit; ready only on the commit edge.
    task automatic send_frame1(input logic [7:0] w, input logic pbit, input logic rdy);
        ready1 = 1'b0;
        d1 = 1'b1;
        tick();
        for (int i = 0; i < W; i++) begin
            d1 = w[i];
            tick();
        end
        d1 = pbit;
        ready1 = rdy;
        tick();
        d1 = 1'b0;
        ready1 = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       rdy;
        logic       drain;
        logic [7:0] exp_do;
        logic       exp_v;
        logic       exp_pe;
        logic       exp_ov;
        logic       exp_v2;
        logic       exp_ov2;
    } vec_t;

    vec_t tbl[8];

    // Randomized stream schedule and buffer model state
    logic       sbit[NCYC];
    logic       sbusy[NCYC];
    logic       scom[NCYC];
    logic [7:0] sword[NCYC];
    logic       serr[NCYC];

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] md, w, v80;
        logic       mv, mp, mo, rdy, hs, pb;
        int         k, gap;

        rst_n = 1'b0; d1 = 1'b0; ready1 = 1'b0; d0 = 1'b0; ready0 = 1'b0;
        tick(); tick();
        check("reset_valid", 32'(valid1), 32'd0);
        check("reset_data", 32'(data1), 32'd0);
        check("reset_perr_ovr_busy", {29'd0, perr1, ovr1, busy1}, 32'd0);
        rst_n = 1'b1;

        //          data   p     rdy   drain do     v     pe    ov    v2    ov2
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h11, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h22, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int r = 0; r < 8; r++) begin
            d1 = 1'b0;
            tick(); tick();
            send_frame1(tbl[r].data, tbl[r].pbit, tbl[r].rdy);
            check($sformatf("tbl%0d_data", r), 32'(data1), 32'(tbl[r].exp_do));
            check($sformatf("tbl%0d_valid", r), 32'(valid1), 32'(tbl[r].exp_v));
            check($sformatf("tbl%0d_perr", r), 32'(perr1), 32'(tbl[r].exp_pe));
            check($sformatf("tbl%0d_ovr", r), 32'(ovr1), 32'(tbl[r].exp_ov));
            check($sformatf("tbl%0d_busy", r), 32'(busy1), 32'd0);
            ready1 = tbl[r].drain;
            tick();
            ready1 = 1'b0;
            check($sformatf("tbl%0d_valid_after", r), 32'(valid1), 32'(tbl[r].exp_v2));
            check($sformatf("tbl%0d_ovr_after", r), 32'(ovr1), 32'(tbl[r].exp_ov2));
        end

        // Latency: valid appears after edge N+9, not N+8
        w = 8'hA5;
        d1 = 1'b1;
        tick();
        check("lat_busy_after_start", 32'(busy1), 32'd1);
        for (int i = 0; i < W; i++) begin
            d1 = w[i];
            tick();
        end
        check("lat_valid_n8", 32'(valid1), 32'd0);
        check("lat_busy_n8", 32'(busy1), 32'd1);
        d1 = 1'b0;
        tick();
        check("lat_valid_n9", 32'(valid1), 32'd1);
        check("lat_data_n9", 32'(data1), 32'hA5);
        check("lat_busy_n9", 32'(busy1), 32'd0);

        // Asynchronous reset in the middle of a frame, buffer still holding 0xA5
        d1 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            d1 = 1'b1;
            tick();
        end
        check("mid_busy", 32'(busy1), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {20'd0, data1, valid1, perr1, ovr1, busy1}, 32'd0);
        tick();
        rst_n = 1'b1;
        d1 = 1'b0;
        tick();
        send_frame1(8'h5A, 1'b0, 1'b0);
        check("post_rst_data", 32'(data1), 32'h5A);
        check("post_rst_valid_perr", {30'd0, valid1, perr1}, 32'b10);
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;

        // No-parity receiver: 0x80 commits on edge N+8
        v80 = 8'h80;
        d0 = 1'b1;
        tick();
        for (int i = 0; i < W; i++) begin
            d0 = v80[i];
            tick();
            if (i == W - 2)
                check("np_valid_n7", 32'(valid0), 32'd0);
        end
        check("np_valid_n8", 32'(valid0), 32'd1);
        check("np_data", 32'(data0), 32'h80);
        check("np_perr_busy", {30'd0, perr0, busy0}, 32'd0);
        d0 = 1'b0;
        ready0 = 1'b1;
        tick();
        ready0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("np_quiet", {29'd0, valid0, busy0, ovr0}, 32'd0);
        end

        // Randomized stream against the reference model
        for (int i = 0; i < NCYC; i++) begin
            sbit[i] = 1'b0; sbusy[i] = 1'b0; scom[i] = 1'b0;
            sword[i] = 8'h00; serr[i] = 1'b0;
        end
        k = 0;
        while (k + 14 < NCYC) begin
            gap = int'($urandom_range(0, 3));
            k += gap;
            sbit[k] = 1'b1; sbusy[k] = 1'b1; k++;
            w = 8'($urandom);
            for (int i = 0; i < W; i++) begin
                sbit[k] = w[i]; sbusy[k] = 1'b1; k++;
            end
            pb = (^w) ^ ($urandom_range(0, 3) == 0);
            sbit[k] = pb; scom[k] = 1'b1; sword[k] = w; serr[k] = (^w) ^ pb;
            k++;
        end

        rst_n = 1'b0;
        d1 = 1'b0; ready1 = 1'b0;
        tick();
        rst_n = 1'b1;
        md = 8'h00; mv = 1'b0; mp = 1'b0; mo = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            rdy = ($urandom_range(0, 3) == 0);
            d1 = sbit[c];
            ready1 = rdy;
            tick();
            hs = mv && rdy;
            if (hs)
                mo = 1'b0;
            if (scom[c]) begin
                if (!mv || rdy) begin
                    md = sword[c]; mv = 1'b1; mp = serr[c];
                end else begin
                    mo = 1'b1;
                end
            end else if (hs) begin
                mv = 1'b0;
            end
            check($sformatf("rand_c%0d", c),
                  {20'd0, busy1, ovr1, perr1, valid1, data1},
                  {20'd0, sbusy[c], mo, mp, mv, md});
        end
        d1 = 1'b0;
        ready1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
